cn_commit_collector: RTL and testbench

- Downstream sequencer for the SM3 party-commitment hasher (Hstart/en_end/hashValue interface).
- Drives one hash per party, indexed by `party_idx`, which upstream uses to mux that party's seed/aux_triangle/salt.
- Captures each 256-bit commitment Cn into an internal buffer.
- Once all parties are hashed, streams the commitments in index order over a valid/ready interface to the challenge-hash stage.

---
 rtl/cn_commit_collector.sv | 161 ++++++++++++++++
 tb/tb_cn_commit_collector.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cn_commit_collector.sv
// cn_commit_collector: sequencer sitting behind the SM3 party-commitment hasher.
// Runs one hash per party (party_idx tells upstream which seed/aux/salt to mux in),
// captures each 256-bit commitment into a local buffer, then streams the buffer in
// index order over a valid/ready interface to the challenge-hash stage.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                one-cycle pulse, accepted only when idle
//   party_idx            party currently being hashed
//   h_start / h_done     hasher Hstart level / en_end
//   h_value              hasher hashValue, valid while h_done is high
//   commit_*             output stream (valid/ready, data, idx, last)
//   busy                 high whenever not idle
//   done                 one-cycle pulse after the final beat transfers
//   error                sticky watchdog flag (always 0 unless CN_TIMEOUT_EN)
//
// Optional build macro: CN_TIMEOUT_EN adds a HASH-state watchdog of TIMEOUT_CYCLES.
module cn_commit_collector #(
   parameter int unsigned NUM_PARTIES    = 16,
   parameter int unsigned IDX_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [IDX_W-1:0] party_idx,
   output logic             h_start,
   input  logic             h_done,
   input  logic [255:0]     h_value,
   output logic             commit_valid,
   input  logic             commit_ready,
   output logic [255:0]     commit_data,
   output logic [IDX_W-1:0] commit_idx,
   output logic             commit_last,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int unsigned AW = (NUM_PARTIES > 1) ? $clog2(NUM_PARTIES) : 1;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PARTIES - 1);

   if (NUM_PARTIES < 2 || (1 << IDX_W) < NUM_PARTIES || TIMEOUT_CYCLES == 0) begin : g_param_err
      $error("cn_commit_collector: illegal parameter combination");
   end

   typedef enum logic [2:0] {StIdle, StArm, StHash, StRelease, StStream, StFin} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] party_q, party_d;
   logic [IDX_W-1:0] rd_q, rd_d;
   logic [255:0]     mem_q [NUM_PARTIES];
   logic             cap;
   logic             timeout;

`ifdef CN_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;

   // h_done in the same cycle wins over the watchdog.
   assign timeout = (state_q == StHash) && !h_done && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign error   = err_q;

   always_comb begin
      cnt_d = (state_q == StHash) ? cnt_q + 1'b1 : '0;
      err_d = err_q;
      if (state_q == StIdle && start) err_d = 1'b0;
      if (timeout)                    err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      party_d      = party_q;
      rd_d         = rd_q;
      cap          = 1'b0;
      h_start      = 1'b0;
      commit_valid = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               state_d = StArm;
               party_d = '0;
            end
         end
         // Hold Hstart low until the hasher has cleared en_end from the previous hash.
         StArm: if (!h_done) state_d = StHash;
         StHash: begin
            h_start = 1'b1;
            if (h_done) begin
               cap     = 1'b1;
               state_d = StRelease;
            end else if (timeout) begin
               state_d = StIdle;
            end
         end
         StRelease: begin
            if (party_q == LastIdx) begin
               state_d = StStream;
               rd_d    = '0;
            end else begin
               party_d = party_q + 1'b1;
               state_d = StArm;
            end
         end
         StStream: begin
            commit_valid = 1'b1;
            if (commit_ready) begin
               if (rd_q == LastIdx) state_d = StFin;
               else                 rd_d    = rd_q + 1'b1;
            end
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         party_q <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         party_q <= party_d;
         rd_q    <= rd_d;
      end
   end

   // Commitment buffer, deliberately not reset.
   always_ff @(posedge clk) begin
      if (cap && !reset) mem_q[party_q[AW-1:0]] <= h_value;
   end

   assign party_idx   = party_q;
   assign commit_data = (state_q == StStream) ? mem_q[rd_q[AW-1:0]] : '0;
   assign commit_idx  = (state_q == StStream) ? rd_q : '0;
   assign commit_last = (state_q == StStream) && (rd_q == LastIdx);

endmodule

// File: tb/tb_cn_commit_collector.sv
// Directed bench for cn_commit_collector with a behavioural SM3 hasher stand-in.
module tb_cn_commit_collector;

   localparam int unsigned NP = 4;
   localparam int unsigned IW = 4;
   localparam int unsigned TO = 20;

   logic          clk = 1'b0;
   logic          reset, start, h_start, h_done, commit_valid, commit_ready;
   logic          commit_last, busy, done, error;
   logic [IW-1:0] party_idx, commit_idx;
   logic [255:0]  h_value, commit_data;

   int errors = 0;
   int checks = 0;

   // Hasher stand-in controls.
   bit       mock_en     = 1'b1;
   int       stale_extra = 0;
   logic [7:0] salt      = 8'h00;
   int       hcnt, drop_cnt;

   // Per-run observations gathered by run_collect.
   int           nbeats, ndone, done_cyc, last_cyc, stall_err, stale_viol, rises;
   bit           timed_out, saw_valid;
   int           bidx [8];
   logic [255:0] bdata [8];
   bit           blast [8];
   int           rise_idx [8];
   logic         pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   always #5 clk = ~clk;

   cn_commit_collector #(
      .NUM_PARTIES   (NP),
      .IDX_W         (IW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .party_idx   (party_idx),
      .h_start     (h_start),
      .h_done      (h_done),
      .h_value     (h_value),
      .commit_valid(commit_valid),
      .commit_ready(commit_ready),
      .commit_data (commit_data),
      .commit_idx  (commit_idx),
      .commit_last (commit_last),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   function automatic logic [255:0] exp_val(input int idx);
      logic [7:0] b;
      b = 8'((idx + 1) * 17) ^ salt;
      return {32{b}};
   endfunction

   // en_end rises 5 cycles after Hstart rises, falls stale_extra+1 cycles after Hstart falls.
   always @(posedge clk) begin
      if (reset) begin
         hcnt     <= 0;
         drop_cnt <= 0;
         h_done   <= 1'b0;
         h_value  <= '0;
      end else if (h_start) begin
         drop_cnt <= 0;
         if (!h_done) begin
            hcnt <= hcnt + 1;
            if (hcnt == 4 && mock_en) begin
               h_done  <= 1'b1;
               h_value <= exp_val(int'(party_idx));
            end
         end
      end else begin
         hcnt <= 0;
         if (h_done) begin
            if (drop_cnt >= stale_extra) h_done <= 1'b0;
            else drop_cnt <= drop_cnt + 1;
         end
      end
   end

   // Starts a run and records beats, done pulses and Hstart rises; no checking here.
   task automatic run_collect(input bit bp, input int busy_party, input int budget);
      logic [255:0]  pd;
      logic [IW-1:0] pi;
      bit stalled = 1'b0, prev_hs = 1'b0, bs_done = 1'b0;
      int k = 0;
      nbeats = 0; ndone = 0; done_cyc = -1; last_cyc = -1; stall_err = 0;
      stale_viol = 0; rises = 0; timed_out = 1'b0; saw_valid = 1'b0;
      pd = '0; pi = '0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (stalled && (commit_valid !== 1'b1 || commit_data !== pd || commit_idx !== pi))
            stall_err++;
         if (h_start === 1'b1 && !prev_hs) begin
            if (h_done === 1'b1) stale_viol++;
            if (rises < 8) rise_idx[rises] = int'(party_idx);
            rises++;
         end
         prev_hs = (h_start === 1'b1);
         if (busy_party >= 0 && !bs_done && h_start === 1'b1 && int'(party_idx) == busy_party) begin
            start   = 1'b1;
            bs_done = 1'b1;
         end
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) done_cyc = c;
         end
         if (commit_valid === 1'b1) begin
            saw_valid    = 1'b1;
            commit_ready = bp ? pat[k % 6] : 1'b1;
            k++;
            if (commit_ready) begin
               if (nbeats < 8) begin
                  bidx[nbeats]  = int'(commit_idx);
                  bdata[nbeats] = commit_data;
                  blast[nbeats] = commit_last;
               end
               nbeats++;
               last_cyc = c;
            end
            stalled = !commit_ready;
            pd      = commit_data;
            pi      = commit_idx;
         end else begin
            stalled      = 1'b0;
            commit_ready = !bp;
         end
         if (ndone > 0 && c >= done_cyc + 3) break;
      end
      if (ndone == 0) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; commit_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (h_start !== 1'b0) begin errors++; $display("FAIL reset_h_start got=%b want=0", h_start); end
      checks++; if (party_idx !== '0) begin errors++; $display("FAIL reset_party_idx got=%0d want=0", party_idx); end
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", commit_valid); end
      checks++; if (commit_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", commit_data); end
      checks++; if (commit_idx !== '0) begin errors++; $display("FAIL reset_idx got=%0d want=0", commit_idx); end
      checks++; if (commit_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", commit_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_start_coincident got=%b want=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b want=0", error); end
      start = 1'b0; reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b want=0", busy); end
   endtask

   task automatic check_run(input string tag, input bit check_stall);
      checks++; if (timed_out) begin errors++; $display("FAIL %s_timeout got=no_done want=done", tag); end
      checks++; if (nbeats != NP) begin errors++; $display("FAIL %s_beats got=%0d want=%0d", tag, nbeats, NP); end
      for (int i = 0; i < NP && i < nbeats; i++) begin
         checks++; if (bidx[i] != i) begin errors++; $display("FAIL %s_idx%0d got=%0d want=%0d", tag, i, bidx[i], i); end
         checks++; if (bdata[i] !== exp_val(i)) begin errors++; $display("FAIL %s_data%0d got=%h want=%h", tag, i, bdata[i], exp_val(i)); end
         checks++; if (blast[i] != (i == NP - 1)) begin errors++; $display("FAIL %s_last%0d got=%b want=%b", tag, i, blast[i], i == NP - 1); end
      end
      checks++; if (ndone != 1) begin errors++; $display("FAIL %s_done_count got=%0d want=1", tag, ndone); end
      checks++; if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL %s_done_timing got=%0d want=%0d", tag, done_cyc, last_cyc + 1); end
      checks++; if (rises != NP) begin errors++; $display("FAIL %s_hstart_rises got=%0d want=%0d", tag, rises, NP); end
      for (int i = 0; i < NP && i < rises; i++) begin
         checks++; if (rise_idx[i] != i) begin errors++; $display("FAIL %s_party_seq%0d got=%0d want=%0d", tag, i, rise_idx[i], i); end
      end
      checks++; if (stale_viol != 0) begin errors++; $display("FAIL %s_stale_entry got=%0d want=0", tag, stale_viol); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got=%b want=0", tag, busy); end
      if (check_stall) begin
         checks++; if (stall_err != 0) begin errors++; $display("FAIL %s_stall_hold got=%0d want=0", tag, stall_err); end
      end
   endtask

   task automatic test_nominal();
      run_collect(1'b0, -1, 400);
      check_run("nominal", 1'b0);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL nominal_error got=%b want=0", error); end
   endtask

   task automatic test_backpressure();
      salt = 8'h3C;
      run_collect(1'b1, -1, 400);
      check_run("backpressure", 1'b1);
   endtask

   task automatic test_stale_done();
      salt = 8'hC3; stale_extra = 3;
      run_collect(1'b0, -1, 400);
      check_run("stale", 1'b0);
      stale_extra = 0;
   endtask

   task automatic test_start_while_busy();
      salt = 8'h0F;
      run_collect(1'b0, 2, 400);
      check_run("busy_start", 1'b0);
   endtask

   task automatic test_reset_mid_run();
      bit found = 1'b0;
      salt = 8'h00;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (h_start === 1'b1 && party_idx === IW'(1)) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL midreset_reach_party1 got=no want=yes"); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (h_start !== 1'b0) begin errors++; $display("FAIL midreset_h_start got=%b want=0", h_start); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", busy); end
      checks++; if (party_idx !== '0) begin errors++; $display("FAIL midreset_party got=%0d want=0", party_idx); end
      reset = 1'b0;
      salt  = 8'h5A;
      run_collect(1'b0, -1, 400);
      check_run("after_reset", 1'b0);
   endtask

`ifdef CN_TIMEOUT_EN
   task automatic test_timeout();
      int hs = 0;
      bit v = 1'b0, d = 1'b0, ended = 1'b0;
      mock_en = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 200 && !ended; c++) begin
         @(negedge clk);
         if (h_start === 1'b1) hs++;
         if (commit_valid === 1'b1) v = 1'b1;
         if (done === 1'b1) d = 1'b1;
         if (busy === 1'b0) ended = 1'b1;
      end
      checks++; if (!ended) begin errors++; $display("FAIL timeout_abort got=busy want=idle"); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error got=%b want=1", error); end
      checks++; if (hs != TO) begin errors++; $display("FAIL timeout_hash_cycles got=%0d want=%0d", hs, TO); end
      checks++; if (h_start !== 1'b0) begin errors++; $display("FAIL timeout_h_start got=%b want=0", h_start); end
      checks++; if (v || d) begin errors++; $display("FAIL timeout_no_stream got=valid%b_done%b want=00", v, d); end
      @(negedge clk);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b want=1", error); end
      mock_en = 1'b1;
      salt    = 8'h99;
      run_collect(1'b0, -1, 400);
      check_run("post_timeout", 1'b0);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_cleared got=%b want=0", error); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got=hang want=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      reset = 1'b1; start = 1'b0; commit_ready = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_stale_done();
      test_start_while_busy();
      test_reset_mid_run();
`ifdef CN_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
